// File: rtl/pc_seq_pkg.sv
// Shared next-PC source encoding and the fixed-priority source selector
// for the program-counter sequencer.
package pc_seq_pkg;

  localparam logic [2:0] SEL_SEQ = 3'd0;
  localparam logic [2:0] SEL_BR  = 3'd1;
  localparam logic [2:0] SEL_J   = 3'd2;
  localparam logic [2:0] SEL_JAL = 3'd3;
  localparam logic [2:0] SEL_JR  = 3'd4;

  // jr > jal > jump > branch > sequential
  function automatic logic [2:0] pick_source(input logic jr, input logic jal,
                                             input logic jump, input logic branch);
    if (jr)          return SEL_JR;
    else if (jal)    return SEL_JAL;
    else if (jump)   return SEL_J;
    else if (branch) return SEL_BR;
    else             return SEL_SEQ;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored, hold freezes everything.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] cnt;

  assign ptr_inc = ptr + PTR_W'(1);
  assign ptr_dec = ptr - PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!hold) begin
      if (push) begin
        // Pointer wrap naturally discards the oldest entry once full.
        ptr          <= ptr_inc;
        mem[ptr_inc] <= push_data;
        if (cnt != FULL) cnt <= cnt + CNT_W'(1);
      end else if (pop && cnt != '0) begin
        ptr <= ptr_dec;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign top   = (cnt == '0) ? '0 : mem[ptr];
  assign count = cnt;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with prioritised next-PC sources, stall, and a
// return-address stack that predicts jr targets and flags mispredictions.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                JT_W      = 26,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       jal,
  input  logic                       jump,
  input  logic                       jr,
  input  logic                       branch,
  input  logic signed [ADDR_W-1:0]   branch_offset,
  input  logic [JT_W-1:0]            jump_target,
  input  logic [ADDR_W-1:0]          jr_target,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          pc_plus1,
  output logic [ADDR_W-1:0]          ras_top,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_mispredict
);

  logic [ADDR_W-1:0] pc_p1;
  logic              mispredict_p1;
  logic [ADDR_W-1:0] np;
  logic [ADDR_W-1:0] pc_next;
  logic [2:0]        sel;
  logic              miss;

  assign np  = pc_p1 + ADDR_W'(1);
  assign sel = pick_source(jr, jal, jump, branch);

  always_comb begin
    pc_next = np;
    case (sel)
      SEL_JR:         pc_next = jr_target;
      SEL_JAL, SEL_J: pc_next = {np[ADDR_W-1:JT_W], jump_target};
      SEL_BR:         pc_next = np + branch_offset;
      default:        pc_next = np;
    endcase
  end

  // An empty stack has no prediction, so any jr against it counts as a miss.
  assign miss = (ras_count == '0) || (ras_top != jr_target);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .hold      (stall),
    .push      (sel == SEL_JAL),
    .pop       (sel == SEL_JR),
    .push_data (np),
    .top       (ras_top),
    .count     (ras_count)
  );

  // Stage p1: architectural PC and mispredict flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p1         <= RESET_PC;
      mispredict_p1 <= 1'b0;
    end else if (!stall) begin
      pc_p1         <= pc_next;
      mispredict_p1 <= (sel == SEL_JR) && miss;
    end
  end

  assign pc             = pc_p1;
  assign pc_plus1       = np;
  assign ras_mispredict = mispredict_p1;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with RESET_PC=0x100 and a 4-deep RAS.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jal = 1'b0, jump = 1'b0, jr = 1'b0, branch = 1'b0;
  logic signed [31:0] branch_offset = '0;
  logic [25:0] jump_target = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc, pc_plus1, ras_top;
  logic [2:0]  ras_count;
  logic        ras_mispredict;

  int applied = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W    (32),
    .JT_W      (26),
    .RAS_DEPTH (4),
    .RESET_PC  (32'h100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .jal            (jal),
    .jump           (jump),
    .jr             (jr),
    .branch         (branch),
    .branch_offset  (branch_offset),
    .jump_target    (jump_target),
    .jr_target      (jr_target),
    .pc             (pc),
    .pc_plus1       (pc_plus1),
    .ras_top        (ras_top),
    .ras_count      (ras_count),
    .ras_mispredict (ras_mispredict)
  );

  typedef struct {
    logic        rst, stl, jl, jmp, jrr, br;
    logic [31:0] off;
    logic [25:0] jt;
    logic [31:0] jrt;
    logic [31:0] exp_pc;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_top;
    logic        exp_mp;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic stl, input logic jl,
                              input logic jmp, input logic jrr, input logic br,
                              input logic [31:0] off, input logic [25:0] jt,
                              input logic [31:0] jrt, input logic [31:0] epc,
                              input logic [2:0] ecnt, input logic [31:0] etop,
                              input logic emp);
    vec_t v;
    v.rst = rst; v.stl = stl; v.jl = jl; v.jmp = jmp; v.jrr = jrr; v.br = br;
    v.off = off; v.jt = jt; v.jrt = jrt;
    v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_top = etop; v.exp_mp = emp;
    return v;
  endfunction

  task automatic apply(input string name, input vec_t v);
    logic [31:0] exp_p1;
    @(negedge clk);
    reset = v.rst; stall = v.stl; jal = v.jl; jump = v.jmp; jr = v.jrr; branch = v.br;
    branch_offset = v.off; jump_target = v.jt; jr_target = v.jrt;
    @(posedge clk);
    #1;
    exp_p1 = v.exp_pc + 32'd1;
    applied++;
    if (pc !== v.exp_pc || pc_plus1 !== exp_p1 || ras_top !== v.exp_top ||
        ras_count !== v.exp_cnt || ras_mispredict !== v.exp_mp) begin
      errors++;
      $display("FAIL %s: got pc=%h p1=%h top=%h cnt=%0d mp=%b, expected pc=%h p1=%h top=%h cnt=%0d mp=%b",
               name, pc, pc_plus1, ras_top, ras_count, ras_mispredict,
               v.exp_pc, exp_p1, v.exp_top, v.exp_cnt, v.exp_mp);
    end
  endtask

  vec_t vecs[$];

  initial begin
    //            rst stl jal jmp jr  br  offset        jt      jr_target     pc            cnt top     mp
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,  32'h0,        32'h100,      0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,  32'h0,        32'h101,      0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,  32'h0,        32'h102,      0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,  32'h0,        32'h103,      0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h200,      32'h200,      0, 32'h0,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hFFFFFFFE, 26'h0,  32'h0,        32'h1FF,      0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h10,       32'h10,       0, 32'h0,  1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'h5,        26'h40, 32'h0,        32'h40,       0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h10,       32'h10,       0, 32'h0,  1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        26'h80, 32'h0,        32'h80,       1, 32'h11, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h11,       32'h11,       0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h50,       32'h50,       0, 32'h0,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,  32'h0,        32'h51,       0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h10,       26'h0,  32'h0,        32'h62,       0, 32'h0,  0));
    // Five pushes of 0x1..0x5 into a 4-deep stack, then five pops.
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h0,        32'h0,        0, 32'h0,  1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        26'h1,  32'h0,        32'h1,        1, 32'h1,  0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        26'h2,  32'h0,        32'h2,        2, 32'h2,  0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        26'h3,  32'h0,        32'h3,        3, 32'h3,  0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        26'h4,  32'h0,        32'h4,        4, 32'h4,  0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        26'h5,  32'h0,        32'h5,        4, 32'h5,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h5,        32'h5,        3, 32'h4,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h4,        32'h4,        2, 32'h3,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h3,        32'h3,        1, 32'h2,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h2,        32'h2,        0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,  32'h1,        32'h1,        0, 32'h0,  1));
    // jal+jr together: only the pop happens, PC follows jr_target.
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        26'h30, 32'h0,        32'h30,       1, 32'h2,  0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 32'h0,        26'h77, 32'h2,        32'h2,        0, 32'h0,  0));

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Stall held for three cycles with jal pending: PC, RAS and the mispredict flag freeze.
    apply("stall_setup", mk(0, 0, 0, 0, 1, 0, 32'h0, 26'h0,  32'h30, 32'h30, 0, 32'h0, 1));
    for (int i = 0; i < 3; i++)
      apply($sformatf("stall%0d", i), mk(0, 1, 1, 0, 0, 0, 32'h0, 26'h99, 32'h0, 32'h30, 0, 32'h0, 1));
    apply("stall_release", mk(0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h31, 0, 32'h0, 0));

    // PC wraps from all-ones to zero.
    apply("wrap_setup", mk(0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0, 1));
    apply("wrap",       mk(0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0,        32'h0,        0, 32'h0, 0));

    // Reset overrides jal and stall, clearing a non-empty stack and a set mispredict.
    apply("rst_jal_a", mk(0, 0, 1, 0, 0, 0, 32'h0, 26'h5, 32'h0, 32'h5, 1, 32'h1, 0));
    apply("rst_jal_b", mk(0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h7, 32'h7, 0, 32'h0, 1));
    apply("rst_jal_c", mk(0, 0, 1, 0, 0, 0, 32'h0, 26'h9, 32'h0, 32'h9, 1, 32'h8, 0));
    apply("rst_jal",   mk(1, 0, 1, 0, 0, 0, 32'h0, 26'h9, 32'h0, 32'h100, 0, 32'h0, 0));
    apply("rst_stl_a", mk(0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h44, 32'h44, 0, 32'h0, 1));
    apply("rst_stall", mk(1, 1, 0, 0, 1, 0, 32'h0, 26'h0, 32'h44, 32'h100, 0, 32'h0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
